sync_marker_tx: RTL and testbench
=================================

Name: sync_marker_tx

Overview:
- Serial frame transmitter, the transmit-side counterpart of the 0110 sequence detector.
- Accepts a parallel payload over a valid/ready handshake and sends a 1-bit-per-clock frame: sync marker 0110, then the payload MSB-first with bit stuffing, then a guard of ones.
- Guarantees that 0110 appears on the line only as the frame marker, even when an overlapping detector monitors the line.
- Feeds the serial input of the downstream marker detector.

Parameters:
DATA_W, 8, payload width in bits (>=1).
GUARD, 3, number of guard '1' bits after the payload; legal range >=3, since fewer cannot prevent a false marker across frame boundaries.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
tx_data  input  DATA_W  payload, sampled on handshake
tx_valid  input  1  payload available
tx_ready  output  1  block can accept a payload; high only in IDLE state (decoded from state register)
out  output  1  serial line, registered; idle level 1
stuff_bit  output  1  registered; high while the current out bit is a stuff bit
frame_done  output  1  registered one-cycle pulse coincident with the last guard bit

Behaviour:
- Reset values (async, immediate):
  - state IDLE; out=1, stuff_bit=0, frame_done=0, tx_ready=1.
  - Shift register, bit counter and history are cleared.
  - A frame in progress is abandoned and the line returns to 1.
- Handshake:
  - Transfer occurs on a rising edge with tx_valid=1 and tx_ready=1; tx_data is latched.
  - tx_valid while busy is ignored; no buffering.
  - tx_data need not be held after the transfer.
- States and transitions:
  - IDLE: out=1. On handshake go to MARK. The first marker bit appears on out the cycle after the handshake edge.
  - MARK: 4 cycles, out = 0,1,1,0. Then go to DATA. History register (last 3 line bits) = 110 at payload start.
  - DATA: each cycle, if history==011, emit a stuff bit: out=1, stuff_bit=1, payload bit not consumed; otherwise emit the next payload bit, MSB first.
    - Stuffing is checked only before a payload bit. No stuff bit follows the final payload bit.
    - After the last payload bit go to GUARD.
  - GUARD: GUARD cycles of out=1; frame_done=1 on the last one. Then go to IDLE.
- History update: shift in every transmitted bit, including stuff bits. A stuff bit always leaves history=111.
- Frame length: 4 + DATA_W + S + GUARD cycles, where S = number of stuff bits (0 <= S <= DATA_W-1). The next handshake is possible no earlier than the first IDLE cycle.
- Counter widths: payload bit counter $clog2(DATA_W+1); guard counter $clog2(GUARD+1). No wrap-around is permitted mid-frame.
- Invariant: concatenating any number of frames and idle periods, 0110 occurs on out exactly once per frame, at the marker position.
- Simultaneous events: reset dominates the handshake. tx_valid asserted in the same cycle frame_done pulses is not accepted, because tx_ready=0 then.

Test Plan:
- Reset then tx_data=8'h66, pulse tx_valid:
  - marker 0110, then payload line 0,1,1,[1],0,0,1,1,[1],0 (stuffs bracketed, stuff_bit high on exactly those 2 cycles), then 111;
  - frame_done in cycle 17 after the handshake; tx_ready=1 in cycle 18.
- tx_data=8'hFF -> payload line 1,1,[1],1,1,1,1,1,1 (9 bits, one stuff); tx_data=8'h00 -> 8 zeros, no stuffs; tx_data=8'h36 -> 0,0,1,1,[1],0,1,1,[1],0.
- Back-to-back frames with tx_valid held high, random payloads over 1000 frames:
  - an overlapping 0110 detector fed from out fires exactly once per frame, on the last marker bit;
  - a destuffing reference model recovers every payload.
- tx_valid pulsed during MARK/DATA/GUARD -> ignored, no frame corruption, tx_ready stays 0 until IDLE.
- Assert reset in the middle of DATA -> out=1 and stuff_bit=0 without waiting for a clock edge; tx_ready=1; the next frame after release is transmitted correctly.
- DATA_W=1 and GUARD=5 build:
  - tx_data=1 -> 0110,1,11111 (no stuff, since history 101);
  - frame_done on the final guard cycle.

Source files
------------

// File: rtl/sync_marker_tx.sv
// Serial frame transmitter: 0110 marker, bit-stuffed MSB-first payload,
// then a run of guard ones. Feeds the downstream marker detector.
module sync_marker_tx #(
  parameter int DATA_W = 8,
  parameter int GUARD  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              out,
  output logic              stuff_bit,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(GUARD + 1);
  localparam logic [BW-1:0] BFULL = BW'(DATA_W);
  localparam logic [GW-1:0] GLAST = GW'(GUARD);
  localparam logic [GW-1:0] GPEN  = GW'(GUARD - 1);

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    DATA,
    GRD
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [BW-1:0]     bitcnt, bitcnt_n;
  logic [GW-1:0]     gcnt, gcnt_n;
  logic [1:0]        mcnt, mcnt_n;
  logic [2:0]        hist, hist_n;
  logic              out_n, stuff_n, done_n;
  logic              emit;

  assign tx_ready = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      gcnt       <= '0;
      mcnt       <= '0;
      hist       <= '0;
      out        <= 1'b1;
      stuff_bit  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bitcnt     <= bitcnt_n;
      gcnt       <= gcnt_n;
      mcnt       <= mcnt_n;
      hist       <= hist_n;
      out        <= out_n;
      stuff_bit  <= stuff_n;
      frame_done <= done_n;
    end
  end

  // Registers hold what is on the line now; this computes the next line bit.
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    gcnt_n   = gcnt;
    mcnt_n   = mcnt;
    out_n    = 1'b1;
    stuff_n  = 1'b0;
    done_n   = 1'b0;
    emit     = 1'b0;

    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          state_n  = MARK;
          mcnt_n   = 2'd0;
          out_n    = 1'b0;
          shreg_n  = tx_data;
          bitcnt_n = BFULL;
        end
      end
      MARK: begin
        if (mcnt == 2'd3) begin
          emit = 1'b1;
        end else begin
          mcnt_n = mcnt + 2'd1;
          out_n  = (mcnt != 2'd2);
        end
      end
      DATA: begin
        if (bitcnt == '0) begin
          state_n = GRD;
          gcnt_n  = GW'(1);
        end else begin
          emit = 1'b1;
        end
      end
      GRD: begin
        if (gcnt == GLAST) begin
          state_n = IDLE;
        end else begin
          gcnt_n = gcnt + GW'(1);
          done_n = (gcnt == GPEN);
        end
      end
      default: state_n = IDLE;
    endcase

    // A line ending in 011 followed by 0 would fake a marker.
    if (emit) begin
      state_n = DATA;
      if (hist == 3'b011) begin
        stuff_n = 1'b1;
      end else begin
        out_n    = shreg[DATA_W-1];
        shreg_n  = shreg << 1;
        bitcnt_n = bitcnt - BW'(1);
      end
    end

    hist_n = {hist[1:0], out_n};
  end

endmodule

// File: tb/tb_sync_marker_tx.sv
// Randomised bench for sync_marker_tx: queue-built frame model,
// line-side 0110 detector and destuffing payload recovery.
module tb_sync_marker_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d0;
  logic       v0, r0, o0, s0, f0;
  logic [0:0] d1;
  logic       v1, r1, o1, s1, f1;
  bit         sel;

  always #5 clk = ~clk;

  sync_marker_tx #(.DATA_W(8), .GUARD(3)) dut (
    .clk(clk), .reset(reset), .tx_data(d0), .tx_valid(v0),
    .tx_ready(r0), .out(o0), .stuff_bit(s0), .frame_done(f0)
  );

  sync_marker_tx #(.DATA_W(1), .GUARD(5)) dut1 (
    .clk(clk), .reset(reset), .tx_data(d1), .tx_valid(v1),
    .tx_ready(r1), .out(o1), .stuff_bit(s1), .frame_done(f1)
  );

  wire ob = sel ? o1 : o0;
  wire sb = sel ? s1 : s0;
  wire fb = sel ? f1 : f0;
  wire rb = sel ? r1 : r0;

  int   n_chk = 0;
  int   n_fail = 0;
  bit   exp_line[$];
  bit   exp_stf[$];
  bit [3:0] det;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build(input logic [31:0] d, input int w, input int g);
    int n;
    exp_line.delete();
    exp_stf.delete();
    exp_line.push_back(1'b0); exp_line.push_back(1'b1);
    exp_line.push_back(1'b1); exp_line.push_back(1'b0);
    repeat (4) exp_stf.push_back(1'b0);
    for (int i = w - 1; i >= 0; i--) begin
      n = exp_line.size();
      if (!exp_line[n-3] && exp_line[n-2] && exp_line[n-1]) begin
        exp_line.push_back(1'b1);
        exp_stf.push_back(1'b1);
      end
      exp_line.push_back(d[i]);
      exp_stf.push_back(1'b0);
    end
    repeat (g) begin
      exp_line.push_back(1'b1);
      exp_stf.push_back(1'b0);
    end
  endtask

  task automatic set_v(input logic v);
    if (sel) v1 = v;
    else v0 = v;
  endtask

  // Entered and left at a negedge with the selected DUT idle.
  // mode 0: valid dropped after handshake, 1: held high, 2: random pulses.
  task automatic run_frame(input logic [31:0] d, input int mode);
    int w, g, rxc, len;
    logic [2:0]  h;
    logic [31:0] rx;
    w = sel ? 1 : 8;
    g = sel ? 5 : 3;
    build(d, w, g);
    len = exp_line.size();
    chk("ready_idle", rb, 1);
    if (sel) d1 = d[0:0];
    else d0 = d[7:0];
    set_v(1'b1);
    @(posedge clk);
    #1;
    if (mode == 0) set_v(1'b0);
    d0 = 8'($urandom);
    d1 = 1'($urandom);
    rx = 0;
    rxc = 0;
    h = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      chk("out", ob, exp_line[i]);
      chk("stuff", sb, exp_stf[i]);
      chk("done", fb, i == len - 1);
      chk("busy_ready", rb, 0);
      det = {det[2:0], ob};
      chk("detector", det == 4'b0110, i == 3);
      if (i == 3) begin
        h = det[2:0];
      end else if (i > 3 && rxc < w) begin
        if (h == 3'b011) begin
          chk("stuff_level", ob, 1);
        end else begin
          rx = {rx[30:0], ob};
          rxc++;
        end
        h = {h[1:0], ob};
      end
      if (mode == 2) set_v(1'($urandom_range(0, 1)));
      if (mode == 2 && i == len - 1) set_v(1'b0);
    end
    chk("payload", rx, d);
    @(negedge clk);
    chk("line_idle", ob, 1);
    chk("ready_back", rb, 1);
    det = {det[2:0], ob};
    chk("detector_idle", det == 4'b0110, 0);
  endtask

  task automatic abort_at(input logic [7:0] d, input int idx);
    d0 = d;
    v0 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    d0 = 8'($urandom);
    repeat (idx + 1) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_out", o0, 1);
    chk("abort_stuff", s0, 0);
    chk("abort_ready", r0, 1);
    chk("abort_done", f0, 0);
    @(negedge clk);
    reset = 1'b0;
    det = 4'hf;
  endtask

  initial begin
    reset = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    d0 = '0;
    d1 = '0;
    sel = 1'b0;
    det = 4'hf;
    #12;
    chk("rst_out", o0, 1);
    chk("rst_stuff", s0, 0);
    chk("rst_done", f0, 0);
    chk("rst_ready", r0, 1);
    chk("rst_out1", o1, 1);
    chk("rst_ready1", r1, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_frame(32'h66, 0);
    run_frame(32'hff, 0);
    run_frame(32'h00, 0);
    run_frame(32'h36, 0);
    for (int k = 0; k < 20; k++) run_frame(32'($urandom_range(0, 255)), 2);

    abort_at(8'h66, 8);
    run_frame(32'ha5, 0);
    abort_at(8'h66, 7);
    run_frame(32'($urandom_range(0, 255)), 0);

    for (int k = 0; k < 1000; k++) run_frame(32'($urandom_range(0, 255)), 1);
    v0 = 1'b0;
    @(negedge clk);

    sel = 1'b1;
    run_frame(32'h1, 0);
    run_frame(32'h0, 0);
    for (int k = 0; k < 20; k++) run_frame(32'($urandom_range(0, 1)), 1);
    v1 = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
